// File: rtl/microwave_controller_pkg.sv
// microwave_controller_pkg: state encodings and BCD constants shared by the controller and display blocks
package microwave_controller_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;
endpackage

// File: rtl/microwave_controller_bcd_time_down.sv
// bcd_time_down: combinational M:SS one-second decrement with a zero flag
//  min_ones/sec_tens/sec_ones : current BCD time
//  dec_*                      : time minus one second, held at 0:00
//  zero                       : current time is 0:00
module bcd_time_down
    import microwave_controller_pkg::*;
(
    input  logic [3:0] min_ones,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    output logic [3:0] dec_min_ones,
    output logic [3:0] dec_sec_tens,
    output logic [3:0] dec_sec_ones,
    output logic       zero
);
    logic borrow_s;
    logic borrow_t;

    assign zero     = ~|{min_ones, sec_tens, sec_ones};
    assign borrow_s = sec_ones == 4'd0;
    assign borrow_t = borrow_s && sec_tens == 4'd0;

    // Tens digit wraps to 5 on a borrow, so a tens value above 5 simply counts down
    assign dec_sec_ones = zero ? 4'd0 : borrow_s ? BCD_NINE : sec_ones - 4'd1;
    assign dec_sec_tens = zero ? 4'd0 : !borrow_s ? sec_tens : borrow_t ? BCD_FIVE : sec_tens - 4'd1;
    assign dec_min_ones = zero ? 4'd0 : borrow_t ? min_ones - 4'd1 : min_ones;
endmodule

// File: rtl/microwave_controller.sv
// microwave_controller: keypad entry, M:SS countdown and cook/pause/done sequencing for the magnetron
//  clk, clearn (sync active-low reset)
//  D/loadn        : encoder digit and active-low load strobe
//  pgt_1hz        : 1 Hz square wave, rising edge = one second
//  startn/stopn   : active-low buttons;  door_closed : 1 = latched
//  keypad_enablen : active-low encoder enable;  mag_on : magnetron;  done : beep request
//  min_ones/sec_tens/sec_ones : BCD cook time
module microwave_controller
    import microwave_controller_pkg::*;
#(
    parameter int BEEP_SECS = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       keypad_enablen,
    output logic       mag_on,
    output logic       done,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);
    localparam int BW = $clog2(BEEP_SECS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);

    state_t        state, state_n;
    logic          loadn_q, startn_q, stopn_q, pgt_q;
    logic          key_ok, start_p, stop_p, tick;
    logic [3:0]    mo_n, st_n, so_n;
    logic [3:0]    dec_mo, dec_st, dec_so;
    logic          zero, dec_zero;
    logic [BW-1:0] beep_cnt, beep_cnt_n;
    logic          mag_on_n, done_n, ken_n;

    assign key_ok   = loadn_q && !loadn && D <= BCD_NINE;
    assign start_p  = startn_q && !startn;
    assign stop_p   = stopn_q && !stopn;
    assign tick     = !pgt_q && pgt_1hz;
    assign dec_zero = ~|{dec_mo, dec_st, dec_so};

    bcd_time_down u_time_down (
        .min_ones     (min_ones),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .dec_min_ones (dec_mo),
        .dec_sec_tens (dec_st),
        .dec_sec_ones (dec_so),
        .zero         (zero)
    );

    always_ff @(posedge clk) begin
        if (!clearn) begin
            state          <= IDLE;
            {min_ones, sec_tens, sec_ones} <= '0;
            beep_cnt       <= '0;
            {loadn_q, startn_q, stopn_q, pgt_q} <= 4'b1110;
            {mag_on, done, keypad_enablen} <= 3'b000;
        end else begin
            state          <= state_n;
            {min_ones, sec_tens, sec_ones} <= {mo_n, st_n, so_n};
            beep_cnt       <= beep_cnt_n;
            {loadn_q, startn_q, stopn_q, pgt_q} <= {loadn, startn, stopn, pgt_1hz};
            {mag_on, done, keypad_enablen} <= {mag_on_n, done_n, ken_n};
        end
    end

    // Event priority: stop > door open > start > key > tick
    always_comb begin
        state_n    = state;
        {mo_n, st_n, so_n} = {min_ones, sec_tens, sec_ones};
        beep_cnt_n = beep_cnt;
        unique case (state)
            IDLE, ENTRY, PAUSE: begin
                if (stop_p) begin
                    state_n = IDLE;
                    {mo_n, st_n, so_n} = '0;
                end else if (start_p && door_closed && state != IDLE && !zero) begin
                    state_n = COOK;
                end else if (key_ok) begin
                    state_n = ENTRY;
                    {mo_n, st_n, so_n} = {sec_tens, sec_ones, D};
                end
            end
            COOK: begin
                if (stop_p || !door_closed) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    {mo_n, st_n, so_n} = {dec_mo, dec_st, dec_so};
                    if (dec_zero) begin
                        state_n    = DONE;
                        beep_cnt_n = '0;
                    end
                end
            end
            DONE: begin
                if (stop_p) state_n = IDLE;
                else if (tick) begin
                    if (beep_cnt == BEEP_LAST) state_n = IDLE;
                    else beep_cnt_n = beep_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                {mo_n, st_n, so_n} = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it
    always_comb begin
        mag_on_n = state_n == COOK;
        done_n   = state_n == DONE;
        ken_n    = state_n == COOK || state_n == DONE;
    end
endmodule
